front_panel_seq: RTL and testbench

Front-panel command sequencer for the Altair 8800 core. It accepts debounced one-cycle switch pulses (examine, examine-next, deposit, deposit-next, run, stop, single-step) and arbitrates between them. It sequences the panel's data-bus jam path: it injects opcode and address bytes on CPU read cycles, issues panel memory writes, and drives the CPU READY line. It sits between the switch debouncers and the CPU/memory bus mux.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_cmd_arb.sv | 42 ++++
 rtl/front_panel_seq.sv | 187 ++++++++++++++++++
 tb/tb_front_panel_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the Altair front-panel sequencer.
package fp_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP,
        ST_EXM_OP,
        ST_EXM_LO,
        ST_EXM_HI,
        ST_NXT_OP,
        ST_DEP_WR
    } fp_state_t;

    // Opcodes jammed onto the CPU data-in bus
    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_NOP = 8'h00;

    // One-hot command selected from the switch pulses (all zero = no command)
    typedef enum logic [6:0] {
        CMD_NONE    = 7'b0000000,
        CMD_EXM     = 7'b0000001,
        CMD_EXM_NXT = 7'b0000010,
        CMD_DEP     = 7'b0000100,
        CMD_DEP_NXT = 7'b0001000,
        CMD_STEP    = 7'b0010000,
        CMD_RUN     = 7'b0100000,
        CMD_STOP    = 7'b1000000
    } fp_cmd_t;

endpackage

// File: rtl/fp_cmd_arb.sv
// Fixed-priority switch arbiter. In HALT: exm > exm_nxt > dep > dep_nxt >
// step > run; in RUN only stop is accepted; nothing is accepted while busy.
// sw_step is honoured only when FP_SINGLE_STEP_EN is defined.
module fp_cmd_arb
    import fp_pkg::*;
(
    input  logic      sw_exm,
    input  logic      sw_exm_nxt,
    input  logic      sw_dep,
    input  logic      sw_dep_nxt,
    input  logic      sw_run,
    input  logic      sw_stop,
    input  logic      sw_step,
    input  logic      busy,
    input  fp_state_t state,
    output fp_cmd_t   cmd
);

`ifdef FP_SINGLE_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    // Pick at most one command; losing pulses are simply dropped
    always_comb begin
        cmd = CMD_NONE;
        if (!busy) begin
            if (state == ST_HALT) begin
                if (sw_exm)                  cmd = CMD_EXM;
                else if (sw_exm_nxt)         cmd = CMD_EXM_NXT;
                else if (sw_dep)             cmd = CMD_DEP;
                else if (sw_dep_nxt)         cmd = CMD_DEP_NXT;
                else if (sw_step && STEP_EN) cmd = CMD_STEP;
                else if (sw_run)             cmd = CMD_RUN;
            end else if (state == ST_RUN) begin
                if (sw_stop) cmd = CMD_STOP;
            end
        end
    end

endmodule

// File: rtl/front_panel_seq.sv
// Altair 8800 front-panel command sequencer: jams JMP/NOP and address bytes
// onto CPU reads, issues panel memory writes and drives READY.
// Optional single-step support is enabled by defining FP_SINGLE_STEP_EN.
module front_panel_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_exm,
    input  logic        sw_exm_nxt,
    input  logic        sw_dep,
    input  logic        sw_dep_nxt,
    input  logic        sw_run,
    input  logic        sw_stop,
    input  logic        sw_step,
    input  logic [15:0] addr_sw,
    input  logic [7:0]  data_sw,
    input  logic        cpu_rd,
    input  logic        cpu_m1,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ready,
    output logic        jam_en,
    output logic [7:0]  jam_data,
    output logic        pnl_wr,
    output logic [15:0] pnl_wr_addr,
    output logic [7:0]  pnl_wr_data,
    output logic        running,
    output logic        busy
);

    fp_state_t   state_reg;
    fp_cmd_t     cmd;
    logic        rd_prev_reg;
    logic        rd_edge_reg;
    logic        m1_reg;
    logic        stop_pend_reg;
    logic        dep_pend_reg;
    logic        rd_edge;

    assign rd_edge = cpu_rd & ~rd_prev_reg;

    fp_cmd_arb u_arb (
        .sw_exm     (sw_exm),
        .sw_exm_nxt (sw_exm_nxt),
        .sw_dep     (sw_dep),
        .sw_dep_nxt (sw_dep_nxt),
        .sw_run     (sw_run),
        .sw_stop    (sw_stop),
        .sw_step    (sw_step),
        .busy       (busy),
        .state      (state_reg),
        .cmd        (cmd)
    );

    // Busy covers every multi-cycle panel sequence
    always_comb begin
        busy = 1'b0;
        case (state_reg)
            ST_EXM_OP, ST_EXM_LO, ST_EXM_HI,
            ST_NXT_OP, ST_DEP_WR, ST_STEP: busy = 1'b1;
            default: ;
        endcase
    end

    // Main sequencer; the read edge is registered once so the FSM acts one
    // cycle after detection, with cpu_m1 captured alongside the edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_HALT;
            rd_prev_reg   <= 1'b0;
            rd_edge_reg   <= 1'b0;
            m1_reg        <= 1'b0;
            stop_pend_reg <= 1'b0;
            dep_pend_reg  <= 1'b0;
            cpu_ready     <= 1'b0;
            jam_en        <= 1'b0;
            jam_data      <= 8'h00;
            pnl_wr        <= 1'b0;
            pnl_wr_addr   <= 16'h0000;
            pnl_wr_data   <= 8'h00;
            running       <= 1'b0;
        end else begin
            rd_prev_reg <= cpu_rd;
            rd_edge_reg <= rd_edge;
            if (rd_edge) m1_reg <= cpu_m1;
            pnl_wr <= 1'b0;

            case (state_reg)
                ST_HALT: begin
                    case (cmd)
                        CMD_EXM: begin
                            jam_data  <= OP_JMP;
                            jam_en    <= 1'b1;
                            cpu_ready <= 1'b1;
                            state_reg <= ST_EXM_OP;
                        end
                        CMD_EXM_NXT, CMD_DEP_NXT: begin
                            jam_data     <= OP_NOP;
                            jam_en       <= 1'b1;
                            cpu_ready    <= 1'b1;
                            dep_pend_reg <= (cmd == CMD_DEP_NXT);
                            state_reg    <= ST_NXT_OP;
                        end
                        CMD_DEP: begin
                            pnl_wr      <= 1'b1;
                            pnl_wr_addr <= cpu_addr;
                            pnl_wr_data <= data_sw;
                            state_reg   <= ST_DEP_WR;
                        end
`ifdef FP_SINGLE_STEP_EN
                        CMD_STEP: begin
                            cpu_ready <= 1'b1;
                            state_reg <= ST_STEP;
                        end
`endif
                        CMD_RUN: begin
                            cpu_ready <= 1'b1;
                            running   <= 1'b1;
                            state_reg <= ST_RUN;
                        end
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    if (cmd == CMD_STOP) stop_pend_reg <= 1'b1;
                    if (rd_edge_reg && m1_reg && stop_pend_reg) begin
                        cpu_ready     <= 1'b0;
                        running       <= 1'b0;
                        stop_pend_reg <= 1'b0;
                        state_reg     <= ST_HALT;
                    end
                end
`ifdef FP_SINGLE_STEP_EN
                ST_STEP: begin
                    // The stalled fetch never re-edges, so the next M1 edge
                    // is the following instruction
                    if (rd_edge_reg && m1_reg) begin
                        cpu_ready <= 1'b0;
                        state_reg <= ST_HALT;
                    end
                end
`endif
                ST_EXM_OP: begin
                    if (rd_edge_reg) begin
                        jam_data  <= addr_sw[7:0];
                        state_reg <= ST_EXM_LO;
                    end
                end
                ST_EXM_LO: begin
                    if (rd_edge_reg) begin
                        jam_data  <= addr_sw[15:8];
                        state_reg <= ST_EXM_HI;
                    end
                end
                ST_EXM_HI: begin
                    if (rd_edge_reg) begin
                        jam_en    <= 1'b0;
                        jam_data  <= 8'h00;
                        cpu_ready <= 1'b0;
                        state_reg <= ST_HALT;
                    end
                end
                ST_NXT_OP: begin
                    // On the new fetch: halt again, and for deposit-next write
                    // straight away at the freshly incremented address
                    if (rd_edge_reg) begin
                        jam_en    <= 1'b0;
                        jam_data  <= 8'h00;
                        cpu_ready <= 1'b0;
                        if (dep_pend_reg) begin
                            pnl_wr       <= 1'b1;
                            pnl_wr_addr  <= cpu_addr;
                            pnl_wr_data  <= data_sw;
                            dep_pend_reg <= 1'b0;
                            state_reg    <= ST_DEP_WR;
                        end else begin
                            state_reg <= ST_HALT;
                        end
                    end
                end
                ST_DEP_WR: state_reg <= ST_HALT;
                default:   state_reg <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_front_panel_seq.sv
// Directed bench for front_panel_seq: a hand-driven CPU bus model walks
// examine, deposit, deposit-next, run/stop, arbitration and reset cases.
module tb_front_panel_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_exm, sw_exm_nxt, sw_dep, sw_dep_nxt, sw_run, sw_stop, sw_step;
    logic [15:0] addr_sw;
    logic [7:0]  data_sw;
    logic        cpu_rd;
    logic        cpu_m1;
    logic [15:0] cpu_addr;
    logic        cpu_ready;
    logic        jam_en;
    logic [7:0]  jam_data;
    logic        pnl_wr;
    logic [15:0] pnl_wr_addr;
    logic [7:0]  pnl_wr_data;
    logic        running;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    front_panel_seq dut (
        .clk         (clk),
        .reset       (reset),
        .sw_exm      (sw_exm),
        .sw_exm_nxt  (sw_exm_nxt),
        .sw_dep      (sw_dep),
        .sw_dep_nxt  (sw_dep_nxt),
        .sw_run      (sw_run),
        .sw_stop     (sw_stop),
        .sw_step     (sw_step),
        .addr_sw     (addr_sw),
        .data_sw     (data_sw),
        .cpu_rd      (cpu_rd),
        .cpu_m1      (cpu_m1),
        .cpu_addr    (cpu_addr),
        .cpu_ready   (cpu_ready),
        .jam_en      (jam_en),
        .jam_data    (jam_data),
        .pnl_wr      (pnl_wr),
        .pnl_wr_addr (pnl_wr_addr),
        .pnl_wr_data (pnl_wr_data),
        .running     (running),
        .busy        (busy)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    // Start a CPU read and wait until the sequencer has reacted to its edge
    task automatic rd_begin(input logic [15:0] a, input logic m1);
        cpu_addr = a;
        cpu_m1   = m1;
        cpu_rd   = 1'b1;
        step();
        step();
    endtask

    task automatic rd_end();
        cpu_rd = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        {sw_exm, sw_exm_nxt, sw_dep, sw_dep_nxt, sw_run, sw_stop, sw_step} = '0;
        addr_sw  = 16'h0000;
        data_sw  = 8'h00;
        cpu_rd   = 1'b1;   // CPU stalled in the fetch of PC=0000
        cpu_m1   = 1'b1;
        cpu_addr = 16'h0000;
        repeat (3) step();

        // Reset state
        check("rst_ready",   cpu_ready, 16'd0);
        check("rst_jam_en",  jam_en,    16'd0);
        check("rst_jam_dat", jam_data,  16'h00);
        check("rst_pnl_wr",  pnl_wr,    16'd0);
        check("rst_running", running,   16'd0);
        check("rst_busy",    busy,      16'd0);
        reset = 1'b0;
        repeat (3) step();

        // Examine 1234 with a simultaneous run pulse: examine wins
        addr_sw = 16'h1234;
        sw_exm = 1'b1; sw_run = 1'b1;
        step();
        sw_exm = 1'b0; sw_run = 1'b0;
        check("exm_jam_op",  jam_data,  16'h00C3);
        check("exm_jam_en",  jam_en,    16'd1);
        check("exm_ready",   cpu_ready, 16'd1);
        check("exm_busy",    busy,      16'd1);
        check("exm_no_run",  running,   16'd0);
        rd_end();
        rd_begin(16'h0001, 1'b0);
        check("exm_jam_lo",  jam_data,  16'h0034);
        check("exm_en_lo",   jam_en,    16'd1);
        // Deposit during EXM_LO is ignored
        data_sw = 8'hEE;
        sw_dep = 1'b1;
        step();
        sw_dep = 1'b0;
        check("exm_dep_ign", pnl_wr,    16'd0);
        step();
        check("exm_dep_ign2", pnl_wr,   16'd0);
        rd_end();
        rd_begin(16'h0002, 1'b0);
        check("exm_jam_hi",  jam_data,  16'h0012);
        check("exm_en_hi",   jam_en,    16'd1);
        rd_end();
        rd_begin(16'h1234, 1'b1);   // fetch at the examined address, stays stalled
        check("exm_done_rdy", cpu_ready, 16'd0);
        check("exm_done_en",  jam_en,    16'd0);
        check("exm_done_bsy", busy,      16'd0);
        step();

        // Deposit A5 at 0100
        cpu_addr = 16'h0100;
        data_sw  = 8'hA5;
        sw_dep = 1'b1;
        step();
        sw_dep = 1'b0;
        check("dep_wr",      pnl_wr,      16'd1);
        check("dep_addr",    pnl_wr_addr, 16'h0100);
        check("dep_data",    pnl_wr_data, 16'h00A5);
        check("dep_ready",   cpu_ready,   16'd0);
        check("dep_busy",    busy,        16'd1);
        step();
        check("dep_wr_1cyc", pnl_wr,      16'd0);
        check("dep_ready2",  cpu_ready,   16'd0);
        check("dep_idle",    busy,        16'd0);

        // Deposit-next 5A: NOP jammed, then write at 0101
        data_sw = 8'h5A;
        sw_dep_nxt = 1'b1;
        step();
        sw_dep_nxt = 1'b0;
        check("dnx_jam_nop", jam_data,  16'h0000);
        check("dnx_jam_en",  jam_en,    16'd1);
        check("dnx_ready",   cpu_ready, 16'd1);
        check("dnx_no_wr",   pnl_wr,    16'd0);
        rd_end();
        rd_begin(16'h0101, 1'b1);
        check("dnx_wr",      pnl_wr,      16'd1);
        check("dnx_addr",    pnl_wr_addr, 16'h0101);
        check("dnx_data",    pnl_wr_data, 16'h005A);
        check("dnx_jam_off", jam_en,      16'd0);
        check("dnx_rdy_off", cpu_ready,   16'd0);
        step();
        check("dnx_wr_1cyc", pnl_wr,      16'd0);
        check("dnx_idle",    busy,        16'd0);

        // Run, stop during non-M1 reads; halt only on the next M1 edge
        sw_run = 1'b1;
        step();
        sw_run = 1'b0;
        check("run_lamp",    running,   16'd1);
        check("run_ready",   cpu_ready, 16'd1);
        check("run_busy",    busy,      16'd0);
        rd_end();
        cpu_addr = 16'h0102; cpu_m1 = 1'b0; cpu_rd = 1'b1;
        step();
        sw_stop = 1'b1;
        step();
        sw_stop = 1'b0;
        step();
        check("stop_nm1_run", running,   16'd1);
        check("stop_nm1_rdy", cpu_ready, 16'd1);
        rd_end();
        rd_begin(16'h0103, 1'b0);
        step();
        check("stop_nm1b",   running,   16'd1);
        rd_end();
        rd_begin(16'h0104, 1'b1);
        check("stop_halt_run", running,   16'd0);
        check("stop_halt_rdy", cpu_ready, 16'd0);
        step();

        // Reset while in EXM_LO
        addr_sw = 16'hBEEF;
        sw_exm = 1'b1;
        step();
        sw_exm = 1'b0;
        rd_end();
        rd_begin(16'h0105, 1'b0);
        check("rexm_lo",     jam_data,  16'h00EF);
        reset = 1'b1;
        step();
        check("rexm_jam_en", jam_en,    16'd0);
        check("rexm_jam_d",  jam_data,  16'h00);
        check("rexm_ready",  cpu_ready, 16'd0);
        check("rexm_busy",   busy,      16'd0);
        reset = 1'b0;
        repeat (3) step();

        // Stop pulse in HALT is a no-op
        sw_stop = 1'b1;
        step();
        sw_stop = 1'b0;
        check("halt_stop_rdy", cpu_ready, 16'd0);
        check("halt_stop_bsy", busy,      16'd0);

        // Single-step
        sw_step = 1'b1;
        step();
        sw_step = 1'b0;
`ifdef FP_SINGLE_STEP_EN
        check("step_ready",  cpu_ready, 16'd1);
        check("step_busy",   busy,      16'd1);
        rd_end();
        rd_begin(16'h0106, 1'b0);
        check("step_nm1",    cpu_ready, 16'd1);
        rd_end();
        rd_begin(16'h0107, 1'b1);
        check("step_halt",   cpu_ready, 16'd0);
        check("step_idle",   busy,      16'd0);
`else
        check("step_ign_rdy", cpu_ready, 16'd0);
        check("step_ign_bsy", busy,      16'd0);
        step();
        check("step_ign_run", running,   16'd0);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
